s2p_wide: RTL and testbench
===========================

# s2p_wide

Parametrised serial-to-parallel converter; the next generation of the 4-bit s2p block. It deserialises an enabled bit stream into WIDTH-bit words and supports MSB-first or LSB-first ordering. Each word is presented on a valid/ready output with a one-entry holding buffer and overrun detection, and an optional per-word parity check can be compiled in. It sits between a serial line receiver and any word-wide consumer in the datapath.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, bit ordering: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s2p_en  input  1  when high, data_in is sampled on this edge; when low, the block pauses.
- data_in  input  1  serial data bit.
- data_out  output  WIDTH  assembled word; reset 0.
- data_out_valid  output  1  data_out holds an unconsumed word; reset 0.
- data_out_ready  input  1  consumer accepts the word when data_out_valid && data_out_ready.
- overrun  output  1  one-cycle pulse when a completed word is dropped; reset 0.
- parity_err  output  1  present only with S2P_PARITY_EN; qualifies data_out; reset 0.

## Operation
- Shift register shreg[WIDTH-1:0] and bit counter cnt (0..WIDTH-1, width $clog2(WIDTH)).
- FSM states: SHIFT and PAR. PAR exists only with S2P_PARITY_EN. Reset state is SHIFT, cnt = 0.
- SHIFT, s2p_en = 1:
  - Sample data_in into shreg. MSB_FIRST = 1: shift left, new bit enters bit 0. MSB_FIRST = 0: shift right, new bit enters bit WIDTH-1.
  - Increment cnt. At cnt = WIDTH-1, the word is complete: cnt wraps to 0.
  - Without the macro, the word is offered to the output buffer on that edge.
  - With the macro, the FSM moves to PAR.
- PAR, s2p_en = 1: data_in is the parity bit. The word is offered together with parity_err = ^word ^ parity_bit (even parity; 1 = error). The FSM returns to SHIFT.
- s2p_en = 0: shreg, cnt and state hold. Gaps of any length are allowed mid-word.
- Output buffer on a word offer:
  - data_out_valid = 0: load the word; valid = 1.
  - data_out_valid = 1 and data_out_ready = 1 on the same edge: load the new word; valid stays 1 (back-to-back, no bubble).
  - data_out_valid = 1 and data_out_ready = 0: drop the new word, keep the old word, pulse overrun for one cycle.
- Handshake with no offer: valid && ready clears valid on the edge. data_out keeps its stale value and must not be interpreted.
- data_out and parity_err are stable while valid && !ready.

## Timing
- The final bit (the parity bit when the macro is set) is sampled at edge N. data_out and data_out_valid update at edge N, so there is zero extra register stage after the last bit.
- Sustained throughput: one word per WIDTH enabled cycles (WIDTH+1 with parity).
- overrun asserts on the edge of the drop and deasserts on the next edge.
- rst asserted at any time, including mid-word or with valid high, clears all of the following:
  - cnt, shreg, state
  - data_out, data_out_valid, overrun, parity_err
- The partial word is discarded. The first enabled bit after rst release is bit 0 of a new word.
- data_out_ready is ignored while data_out_valid = 0.

## Configuration
- S2P_PARITY_EN defined:
  - PAR state, parity_err port and parity register are present.
  - Each word consumes WIDTH+1 enabled bits.
  - parity_err is loaded with data_out on every accepted offer.
- S2P_PARITY_EN undefined:
  - No PAR state and no parity_err port.
  - Each word is exactly WIDTH enabled bits.

## Structure
- Package s2p_pkg holds:
  - FSM state typedef (S2P_SHIFT, S2P_PAR)
  - reset-value constants
  - shared parity-function helper
- Sub-module s2p_out_buf: one-entry holding register with valid/ready handshake and overrun pulse. Parametrised by WIDTH; carries parity_err as an extra payload bit when the macro is set.
- The top level contains the shift register, counter and FSM, and instantiates s2p_out_buf.

## Test plan
- WIDTH=8, MSB_FIRST=1, ready held 1, s2p_en=1, bits 1,0,1,1,0,0,1,0 → data_out=8'hB2; data_out_valid rises on the 8th sampling edge.
- WIDTH=8, MSB_FIRST=0, same bits → data_out=8'h4D.
- Same stream as the first scenario with s2p_en low for 3 cycles after bit 4 → data_out=8'hB2; valid delayed by exactly 3 cycles.
- ready held 0; send 8'hB2 then 8'h0F → overrun pulses for 1 cycle on the 16th bit edge; data_out remains 8'hB2. Raising ready then clears valid.
- rst pulsed after 5 bits of a word, then 8 bits 0,0,0,0,1,1,1,1 → valid 0 during reset; next word is data_out=8'h0F.
- S2P_PARITY_EN, MSB_FIRST=1, bits of 8'hB2 followed by parity bit 0 → parity_err=0; followed by parity bit 1 → parity_err=1, data_out=8'hB2 in both cases.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared definitions for the s2p_wide serial-to-parallel converter.
// Optional feature macro: S2P_PARITY_EN (per-word even-parity check).
package s2p_pkg;

    // FSM state encoding; S2P_PAR is only reachable with S2P_PARITY_EN.
    typedef logic [0:0] s2p_state_t;
    localparam s2p_state_t S2P_SHIFT = 1'b0;
    localparam s2p_state_t S2P_PAR   = 1'b1;

    // Reset values of single-bit state; wide registers reset to all-zero.
    localparam s2p_state_t RST_STATE   = S2P_SHIFT;
    localparam logic       RST_VALID   = 1'b0;
    localparam logic       RST_OVERRUN = 1'b0;
    localparam logic       RST_PERR    = 1'b0;

    // Even parity: the word's XOR reduction plus the received parity bit must be 0.
    function automatic logic parity_err_calc(input logic word_xor, input logic parity_bit);
        return word_xor ^ parity_bit;
    endfunction

endpackage

// File: rtl/s2p_out_buf.sv
// One-entry output holding register with valid/ready handshake and overrun pulse.
// Optional feature macro: S2P_PARITY_EN (adds a parity-error payload bit).
module s2p_out_buf
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             offer_i,
    input  logic [WIDTH-1:0] word_i,
`ifdef S2P_PARITY_EN
    input  logic             perr_i,
    output logic             perr_o,
`endif
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             load;
`ifdef S2P_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Accept an offer when empty or when the held word leaves on this edge.
    always_comb begin
        load      = offer_i && (!valid_q || ready_i);
        overrun_d = offer_i && valid_q && !ready_i;
        data_d    = load ? word_i : data_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
`ifdef S2P_PARITY_EN
        perr_d = load ? perr_i : perr_q;
`endif
    end

    // Output state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= RST_VALID;
            overrun_q <= RST_OVERRUN;
`ifdef S2P_PARITY_EN
            perr_q    <= RST_PERR;
`endif
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef S2P_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
`ifdef S2P_PARITY_EN
    assign perr_o    = perr_q;
`endif

endmodule

// File: rtl/s2p_wide.sv
// Parametrised serial-to-parallel converter: shift register, bit counter and
// framing FSM feeding a one-entry output buffer.
// Optional feature macro: S2P_PARITY_EN (trailing even-parity bit per word).
module s2p_wide
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s2p_en,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
`ifdef S2P_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int unsigned     CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             offer;
    logic [WIDTH-1:0] offer_word;
`ifdef S2P_PARITY_EN
    s2p_state_t       state_q, state_d;
    logic             offer_perr;
`endif

    // Next shift/count/state; offer a word when its last bit (or parity bit) arrives.
    always_comb begin
        shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], data_in} : {data_in, shreg_q[WIDTH-1:1]};
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        offer      = 1'b0;
        offer_word = shifted;
`ifdef S2P_PARITY_EN
        state_d    = state_q;
        offer_perr = 1'b0;
        if (s2p_en) begin
            if (state_q == S2P_PAR) begin
                // Completed word is already in shreg; data_in is its parity bit.
                offer      = 1'b1;
                offer_word = shreg_q;
                offer_perr = parity_err_calc(^shreg_q, data_in);
                state_d    = S2P_SHIFT;
            end else begin
                shreg_d = shifted;
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = S2P_PAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
`else
        if (s2p_en) begin
            shreg_d = shifted;
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                offer = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    // Deserialiser state registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef S2P_PARITY_EN
            state_q <= RST_STATE;
`endif
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef S2P_PARITY_EN
            state_q <= state_d;
`endif
        end
    end

    s2p_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .offer_i   (offer),
        .word_i    (offer_word),
`ifdef S2P_PARITY_EN
        .perr_i    (offer_perr),
        .perr_o    (parity_err),
`endif
        .ready_i   (data_out_ready),
        .data_o    (data_out),
        .valid_o   (data_out_valid),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_s2p_wide.sv
// Self-checking bench for s2p_wide: one MSB-first and one LSB-first instance
// share the same stimulus. Table vectors, hand sequences, then random traffic
// compared against a bit-queue reference model.
module tb_s2p_wide;

    localparam int W = 8;
`ifdef S2P_PARITY_EN
    localparam int BPW = W + 1;
`else
    localparam int BPW = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s2p_en;
    logic         data_in;
    logic         data_out_ready;
    logic [W-1:0] dout_m, dout_l;
    logic         valid_m, valid_l, ovr_m, ovr_l;
`ifdef S2P_PARITY_EN
    logic         perr_m, perr_l;
`endif

    always #5 clk = ~clk;

    s2p_wide #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk            (clk),
        .rst            (rst),
        .s2p_en         (s2p_en),
        .data_in        (data_in),
        .data_out       (dout_m),
        .data_out_valid (valid_m),
        .data_out_ready (data_out_ready),
`ifdef S2P_PARITY_EN
        .parity_err     (perr_m),
`endif
        .overrun        (ovr_m)
    );

    s2p_wide #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk            (clk),
        .rst            (rst),
        .s2p_en         (s2p_en),
        .data_in        (data_in),
        .data_out       (dout_l),
        .data_out_valid (valid_l),
        .data_out_ready (data_out_ready),
`ifdef S2P_PARITY_EN
        .parity_err     (perr_l),
`endif
        .overrun        (ovr_l)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: received bits queue up until a full frame is present.
    bit           bq[$];
    logic         m_valid, m_ovr;
    logic [W-1:0] m_dm, m_dl;
`ifdef S2P_PARITY_EN
    logic         m_perr;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_dm    = '0;
        m_dl    = '0;
`ifdef S2P_PARITY_EN
        m_perr  = 1'b0;
`endif
    endtask

    task automatic model_edge(input logic en, input logic d, input logic rdy);
        logic         offer;
        logic [W-1:0] wm, wl;
`ifdef S2P_PARITY_EN
        logic         pe;
        pe = 1'b0;
`endif
        offer = 1'b0;
        wm    = '0;
        wl    = '0;
        m_ovr = 1'b0;
        if (en) begin
            bq.push_back(d);
            if (bq.size() == BPW) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = bq[i];
                    wl[i]     = bq[i];
                end
`ifdef S2P_PARITY_EN
                pe = (^wm) ^ bq[W];
`endif
                bq.delete();
                offer = 1'b1;
            end
        end
        if (offer) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_dm    = wm;
                m_dl    = wl;
`ifdef S2P_PARITY_EN
                m_perr  = pe;
`endif
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, advance through the edge, sample 1 time unit later.
    task automatic tick(input logic en, input logic d, input logic rdy);
        s2p_en         = en;
        data_in        = d;
        data_out_ready = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(en, d, rdy);
        #1;
    endtask

    task automatic check_model();
        chk("valid_m", valid_m, m_valid);
        chk("valid_l", valid_l, m_valid);
        chk("ovr_m", ovr_m, m_ovr);
        chk("ovr_l", ovr_l, m_ovr);
        if (m_valid) begin
            chk("data_m", dout_m, m_dm);
            chk("data_l", dout_l, m_dl);
`ifdef S2P_PARITY_EN
            chk("perr_m", perr_m, m_perr);
            chk("perr_l", perr_l, m_perr);
`endif
        end
    endtask

    // Send one frame; seq[W-1] is the first bit on the line. Gap inserted before bit gap_at.
    task automatic send_word(input logic [W-1:0] seq, input int gap_at, input int gap_len,
                             input logic rdy, input logic pflip, input logic chk_t);
        logic b[BPW];
        for (int i = 0; i < W; i++) b[i] = seq[W-1-i];
`ifdef S2P_PARITY_EN
        b[W] = (^seq) ^ pflip;
`else
        if (pflip) $display("note: parity flip ignored in this build");
`endif
        for (int i = 0; i < BPW; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) tick(1'b0, 1'b1, rdy);
            end
            if (chk_t && i == BPW - 1) chk("valid_before_last", valid_m, 1'b0);
            tick(1'b1, b[i], rdy);
        end
    endtask

    typedef struct {
        logic [W-1:0] seq;
        int           gap_at;
        int           gap_len;
        logic [W-1:0] exp_m;
        logic [W-1:0] exp_l;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{seq: 8'hB2, gap_at: 0, gap_len: 0, exp_m: 8'hB2, exp_l: 8'h4D};
        vt[1] = '{seq: 8'hB2, gap_at: 4, gap_len: 3, exp_m: 8'hB2, exp_l: 8'h4D};
        vt[2] = '{seq: 8'h0F, gap_at: 0, gap_len: 0, exp_m: 8'h0F, exp_l: 8'hF0};
        vt[3] = '{seq: 8'hFE, gap_at: 7, gap_len: 5, exp_m: 8'hFE, exp_l: 8'h7F};
        vt[4] = '{seq: 8'h80, gap_at: 1, gap_len: 1, exp_m: 8'h80, exp_l: 8'h01};

        rst            = 1'b1;
        s2p_en         = 1'b0;
        data_in        = 1'b0;
        data_out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_data", dout_m, 8'h00);
        chk("rst_ovr", ovr_m, 1'b0);
        rst = 1'b0;

        // Table: ready held high, valid must rise exactly on the last bit's edge.
        for (int v = 0; v < 5; v++) begin
            send_word(vt[v].seq, vt[v].gap_at, vt[v].gap_len, 1'b1, 1'b0, 1'b1);
            chk("tbl_valid", valid_m, 1'b1);
            chk("tbl_data_m", dout_m, vt[v].exp_m);
            chk("tbl_data_l", dout_l, vt[v].exp_l);
            tick(1'b0, 1'b0, 1'b1);
            chk("tbl_handshake_clr", valid_m, 1'b0);
        end

        // Overrun: hold B2, then a second word is dropped with a one-cycle pulse.
        send_word(8'hB2, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("ovr_first_valid", valid_m, 1'b1);
        chk("ovr_first_data", dout_m, 8'hB2);
        send_word(8'h0F, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", ovr_m, 1'b1);
        chk("ovr_keep_data", dout_m, 8'hB2);
        chk("ovr_keep_valid", valid_m, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("ovr_pulse_end", ovr_m, 1'b0);
        chk("ovr_stable_data", dout_m, 8'hB2);
        tick(1'b0, 1'b0, 1'b1);
        chk("ovr_ready_clr", valid_m, 1'b0);

        // Back-to-back: held word leaves on the same edge the next one loads.
        send_word(8'h3C, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < BPW - 1; i++) tick(1'b1, i[0], 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        chk("b2b_valid", valid_m, 1'b1);
        chk("b2b_ovr", ovr_m, 1'b0);
        check_model();
        tick(1'b0, 1'b0, 1'b1);

        // Async reset mid-word with a word pending.
        send_word(8'hA5, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", valid_m, 1'b0);
        chk("arst_data", dout_m, 8'h00);
        chk("arst_ovr", ovr_m, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("arst_hold_valid", valid_m, 1'b0);
        rst = 1'b0;
        send_word(8'h0F, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("post_rst_valid", valid_m, 1'b1);
        chk("post_rst_data_m", dout_m, 8'h0F);
        chk("post_rst_data_l", dout_l, 8'hF0);
        tick(1'b0, 1'b0, 1'b1);

`ifdef S2P_PARITY_EN
        send_word(8'hB2, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("par_ok_data", dout_m, 8'hB2);
        chk("par_ok_err", perr_m, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        send_word(8'hB2, 0, 0, 1'b1, 1'b1, 1'b1);
        chk("par_bad_data", dout_m, 8'hB2);
        chk("par_bad_err", perr_m, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
`endif

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                tick(1'b0, 1'b0, 1'b0);
                rst = 1'b0;
            end
            tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
